fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised operand forwarding and hazard unit for the RVCPU pipeline, feeding the register-read stage. It generalises the fixed-stage forwarding unit in three ways: any number of producer stages, any number of read ports, and a 32-entry scoreboard of pending long-latency writes (multi-cycle MUL/DIV, cache-miss loads). It also has a consecutive-stall watchdog. Forwarding and stall outputs are combinational; the scoreboard, watchdog and optional statistics are sequential.

## Interface
Parameters:
- XLEN, 64, datapath width.
- NSTAGE, 5, number of producer stages; index 0 = youngest (nearest register read).
- NREAD, 2, number of operand read ports.
- TIMEOUT, 255, consecutive stall cycles before `hang` asserts; range 1..65535.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_addr  in  NREAD*5  source register per read port; port i at [5i+4:5i].
- stage_rd  in  NSTAGE*5  destination register per stage.
- stage_wr_en  in  NSTAGE  stage will write the register file.
- stage_data_valid  in  NSTAGE  stage result is available this cycle (0 for load before data return, EX-first-half, etc.).
- stage_data  in  NSTAGE*XLEN  stage write-back value.
- issue_valid  in  1  instruction leaves register-read this cycle.
- issue_rd  in  5  its destination.
- issue_long  in  1  it is long-latency; its result arrives via lret_*.
- lret_valid  in  1  long-latency result written back this cycle.
- lret_rd  in  5  its destination.
- fwd_data  out  NREAD*XLEN  forwarded value per port.
- fwd_sel  out  NREAD  1 = use fwd_data, 0 = use register file.
- stall  out  1  hold register-read stage.
- hang  out  1  sticky watchdog flag.
- stall_cycles  out  32  total stall cycles (only with FWD_STALL_STATS_EN).

## Operation
- Per port i, scan stages 0..NSTAGE-1. The first stage s with stage_wr_en[s], stage_rd[s]!=0 and stage_rd[s]==rs_addr[i] is the match.
  - If stage_data_valid[s] is 1: fwd_sel[i]=1 and fwd_data[i]=stage_data[s].
  - If stage_data_valid[s] is 0: port hazard, fwd_sel[i]=1 and fwd_data[i]=0.
- No stage match and pend[rs_addr[i]]=1: port hazard, fwd_sel[i]=0, fwd_data[i]=0.
- No match and not pending: fwd_sel[i]=0, fwd_data[i]=0.
- rs_addr=0 never matches and never hazards.
- stall = OR of all port hazards.
- pend[31:0] scoreboard register:
  - Set bit issue_rd when issue_valid & issue_long & !stall & issue_rd!=0.
  - Clear bit lret_rd when lret_valid.
  - Set and clear of the same bit in the same cycle: set wins (a newer op claims the register).
  - pend[0] is always 0.
- Watchdog counter wd (16 bit):
  - stall=1: wd increments, saturating at TIMEOUT.
  - stall=0: wd returns to 0.
  - wd reaching TIMEOUT sets hang; hang stays set until reset.

## Timing
- Forwarding and stall: 0-cycle latency, combinational from inputs and current pend.
- pend updates on the clock edge after issue or return. A dependent read issued the cycle after a long issue sees pend=1.
- A dependent read in the same cycle as lret_valid for that register still sees pend=1 and stalls one cycle, unless the write-back value is also presented on a stage input.
- Reset values: pend=0, wd=0, hang=0, stall_cycles=0. Combinational outputs follow inputs during reset.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- hang rises on the edge where wd transitions TIMEOUT-1 -> TIMEOUT, i.e. after TIMEOUT consecutive stall cycles.

## Configuration
- FWD_STALL_STATS_EN defined:
  - stall_cycles increments by 1 on every clock edge with stall=1 and wraps at 2^32.
  - It is never cleared except by reset.
- FWD_STALL_STATS_EN undefined:
  - Counter logic is removed and stall_cycles is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Priority: stage0 and stage2 both write x5 with valid data 0xA and 0xB, rs_addr port0=5 -> fwd_sel[0]=1, fwd_data[0]=0xA, stall=0.
- Load-use: stage0 writes x7 with data_valid=0, port1 reads x7 -> stall=1, fwd_sel[1]=1. Next cycle data_valid=1, data 0x1234 -> stall=0, fwd_data[1]=0x1234.
- Scoreboard: issue_long to x9; next cycle port0 reads x9 with no stage match -> stall=1. Assert lret_valid x9 -> the following cycle stall=0 and fwd_sel[0]=0.
- Simultaneous events: lret_valid x9 and issue_long x9 in the same cycle -> pend[9] stays 1. A read of x0 with every stage writing x0 -> fwd_sel=0, stall=0.
- Watchdog: TIMEOUT=4, hold a hazard -> hang=1 after the 4th stall edge. Release the stall -> hang stays 1. Pulse rst_n low -> hang=0, pend=0.
- Statistics: with FWD_STALL_STATS_EN, 10 stall cycles -> stall_cycles=10. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard -- operand forwarding and hazard unit for the register-read stage.
//
// Purpose:
//   Per read port, picks the youngest producer stage writing the source register
//   and forwards its value, or flags a hazard when that value is not ready yet.
//   A 32-bit scoreboard tracks long-latency writes (MUL/DIV, missed loads) that
//   are no longer visible in any stage. A watchdog raises a sticky hang flag
//   after TIMEOUT consecutive stall cycles.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   rs_addr_i             NREAD x 5    source register per read port
//   stage_rd_i            NSTAGE x 5   destination per producer stage (0 = youngest)
//   stage_wr_en_i         NSTAGE       stage writes the register file
//   stage_data_valid_i    NSTAGE       stage result available this cycle
//   stage_data_i          NSTAGE x XLEN stage result
//   issue_valid_i/rd_i/long_i          instruction leaving register-read
//   lret_valid_i/rd_i                  long-latency write-back
//   fwd_data_o            NREAD x XLEN forwarded value per port
//   fwd_sel_o             NREAD        1 = use fwd_data
//   stall_o               hold register-read
//   hang_o                sticky watchdog flag
//   stall_cycles_o        total stall cycles
//
// Optional feature macro: FWD_STALL_STATS_EN enables the stall_cycles counter;
// without it stall_cycles_o is tied to 0.

// Per-port forwarding selector: youngest matching stage wins.
module fwd_port #(
  parameter int XLEN   = 64,
  parameter int NSTAGE = 5
) (
  input  logic [4:0]                   rs_i,
  input  logic [NSTAGE-1:0][4:0]       st_rd_i,
  input  logic [NSTAGE-1:0]            st_wr_en_i,
  input  logic [NSTAGE-1:0]            st_dv_i,
  input  logic [NSTAGE-1:0][XLEN-1:0]  st_data_i,
  input  logic [31:0]                  pend_i,
  output logic                         sel_o,
  output logic [XLEN-1:0]              data_o,
  output logic                         hazard_o
);
  logic hit;

  always_comb begin
    hit      = 1'b0;
    sel_o    = 1'b0;
    data_o   = '0;
    hazard_o = 1'b0;
    for (int s = 0; s < NSTAGE; s++) begin
      if (!hit && st_wr_en_i[s] && (st_rd_i[s] != 5'd0) && (st_rd_i[s] == rs_i)) begin
        hit   = 1'b1;
        sel_o = 1'b1;
        // A matching stage without its data yet still claims the port:
        // older stages hold stale values for this register.
        if (st_dv_i[s]) data_o   = st_data_i[s];
        else            hazard_o = 1'b1;
      end
    end
    // Scoreboard only matters once no in-flight stage carries the register.
    if (!hit && (rs_i != 5'd0) && pend_i[rs_i]) hazard_o = 1'b1;
  end
endmodule

module fwd_scoreboard #(
  parameter int XLEN    = 64,
  parameter int NSTAGE  = 5,
  parameter int NREAD   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*5-1:0]       rs_addr_i,
  input  logic [NSTAGE*5-1:0]      stage_rd_i,
  input  logic [NSTAGE-1:0]        stage_wr_en_i,
  input  logic [NSTAGE-1:0]        stage_data_valid_i,
  input  logic [NSTAGE*XLEN-1:0]   stage_data_i,
  input  logic                     issue_valid_i,
  input  logic [4:0]               issue_rd_i,
  input  logic                     issue_long_i,
  input  logic                     lret_valid_i,
  input  logic [4:0]               lret_rd_i,
  output logic [NREAD*XLEN-1:0]    fwd_data_o,
  output logic [NREAD-1:0]         fwd_sel_o,
  output logic                     stall_o,
  output logic                     hang_o,
  output logic [31:0]              stall_cycles_o
);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  logic [NREAD-1:0][4:0]         rs;
  logic [NSTAGE-1:0][4:0]        st_rd;
  logic [NSTAGE-1:0][XLEN-1:0]   st_data;
  logic [NREAD-1:0][XLEN-1:0]    fwd_data;
  logic [NREAD-1:0]              hazard;

  logic [31:0] pend_q, pend_d;
  logic [15:0] wd_q, wd_d;
  logic        hang_q, hang_d;

  assign rs         = rs_addr_i;
  assign st_rd      = stage_rd_i;
  assign st_data    = stage_data_i;
  assign fwd_data_o = fwd_data;

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    fwd_port #(.XLEN(XLEN), .NSTAGE(NSTAGE)) u_port (
      .rs_i       (rs[i]),
      .st_rd_i    (st_rd),
      .st_wr_en_i (stage_wr_en_i),
      .st_dv_i    (stage_data_valid_i),
      .st_data_i  (st_data),
      .pend_i     (pend_q),
      .sel_o      (fwd_sel_o[i]),
      .data_o     (fwd_data[i]),
      .hazard_o   (hazard[i])
    );
  end

  assign stall_o = |hazard;
  assign hang_o  = hang_q;

  // Scoreboard: clear first so a same-cycle set (newer op) wins.
  always_comb begin
    pend_d = pend_q;
    if (lret_valid_i) pend_d[lret_rd_i] = 1'b0;
    if (issue_valid_i && issue_long_i && !stall_o && (issue_rd_i != 5'd0))
      pend_d[issue_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Watchdog: saturating count of consecutive stalls; hang latches on reaching TO.
  always_comb begin
    if (stall_o) wd_d = (wd_q >= TO) ? TO : wd_q + 16'd1;
    else         wd_d = 16'd0;
    hang_d = hang_q | (stall_o && (wd_d == TO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      wd_q   <= '0;
      hang_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      wd_q   <= wd_d;
      hang_q <= hang_d;
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  assign stall_cycles_d = stall_o ? stall_cycles_q + 32'd1 : stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles_o = stall_cycles_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed + random bench for fwd_scoreboard against a behavioural model.
module tb_fwd_scoreboard;
  localparam int XLEN = 64, NSTAGE = 5, NREAD = 2, TIMEOUT = 4;
`ifdef FWD_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREAD*5-1:0]     rs_addr;
  logic [NSTAGE*5-1:0]    stage_rd;
  logic [NSTAGE-1:0]      stage_wr_en, stage_dv;
  logic [NSTAGE*XLEN-1:0] stage_data;
  logic                   issue_valid, issue_long, lret_valid;
  logic [4:0]             issue_rd, lret_rd;
  logic [NREAD*XLEN-1:0]  fwd_data;
  logic [NREAD-1:0]       fwd_sel;
  logic                   stall, hang;
  logic [31:0]            stall_cycles;

  int n_chk = 0, n_fail = 0;

  // Model state, kept as plain variables.
  bit          pend_m [32];
  int          wd_m;
  bit          hang_m;
  int unsigned stalls_m;

  always #5 clk = ~clk;

  fwd_scoreboard #(.XLEN(XLEN), .NSTAGE(NSTAGE), .NREAD(NREAD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .stage_rd_i(stage_rd),
    .stage_wr_en_i(stage_wr_en), .stage_data_valid_i(stage_dv), .stage_data_i(stage_data),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_long_i(issue_long),
    .lret_valid_i(lret_valid), .lret_rd_i(lret_rd), .fwd_data_o(fwd_data),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .hang_o(hang), .stall_cycles_o(stall_cycles));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (pend_m[r]) pend_m[r] = 1'b0;
    wd_m = 0; hang_m = 1'b0; stalls_m = 0;
  endfunction

  // Expected per-port result: youngest writer of the register decides.
  function automatic void model_port(input int i, output bit sel, output logic [63:0] d, output bit hz);
    int r   = int'(rs_addr[5*i +: 5]);
    int hit = -1;
    sel = 0; d = '0; hz = 0;
    if (r == 0) return;
    for (int s = NSTAGE-1; s >= 0; s--)
      if (stage_wr_en[s] && int'(stage_rd[5*s +: 5]) == r) hit = s;
    if (hit >= 0) begin
      sel = 1;
      if (stage_dv[hit]) d = stage_data[XLEN*hit +: XLEN];
      else               hz = 1;
    end else if (pend_m[r]) hz = 1;
  endfunction

  function automatic void model_clock(input bit st);
    if (lret_valid) pend_m[lret_rd] = 1'b0;
    if (issue_valid && issue_long && !st && issue_rd != 0) pend_m[issue_rd] = 1'b1;
    if (st) begin
      wd_m = (wd_m + 1 > TIMEOUT) ? TIMEOUT : wd_m + 1;
      if (wd_m == TIMEOUT) hang_m = 1'b1;
      stalls_m++;
    end else wd_m = 0;
  endfunction

  task automatic clear_in();
    rs_addr = '0; stage_rd = '0; stage_wr_en = '0; stage_dv = '0; stage_data = '0;
    issue_valid = 0; issue_long = 0; issue_rd = '0; lret_valid = 0; lret_rd = '0;
  endtask

  // Check every output against the model, then clock once. Called just after negedge.
  task automatic step();
    bit sel, hz, st;
    logic [63:0] d;
    st = 0;
    #1;
    for (int i = 0; i < NREAD; i++) begin
      model_port(i, sel, d, hz);
      st |= hz;
      chk($sformatf("fwd_sel[%0d]", i), 64'(fwd_sel[i]), 64'(sel));
      chk($sformatf("fwd_data[%0d]", i), fwd_data[XLEN*i +: XLEN], d);
    end
    chk("stall", 64'(stall), 64'(st));
    chk("hang", 64'(hang), 64'(hang_m));
    chk("stall_cycles", 64'(stall_cycles), STATS ? 64'(stalls_m) : 64'd0);
    @(posedge clk);
    model_clock(st);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2 rst_n = 0;
    #1 model_reset();
    chk("rst_hang", 64'(hang), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    #1 rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    model_reset();
    #2;
    chk("reset_hang", 64'(hang), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_stall_cycles", 64'(stall_cycles), 64'd0);
    @(negedge clk); rst_n = 1; @(negedge clk);

    // Priority: stage0 and stage2 both write x5.
    stage_rd[0 +: 5] = 5; stage_rd[10 +: 5] = 5; stage_wr_en = 5'b00101; stage_dv = 5'b00101;
    stage_data[0 +: 64] = 64'hA; stage_data[128 +: 64] = 64'hB; rs_addr[4:0] = 5;
    #1 chk("prio_data", fwd_data[63:0], 64'hA);
    chk("prio_sel", 64'(fwd_sel[0]), 64'd1);
    step();

    // Load-use on port 1.
    clear_in();
    stage_rd[0 +: 5] = 7; stage_wr_en = 5'b00001; rs_addr[9:5] = 7;
    #1 chk("lu_stall", 64'(stall), 64'd1);
    step();
    stage_dv = 5'b00001; stage_data[0 +: 64] = 64'h1234;
    #1 chk("lu_data", fwd_data[127:64], 64'h1234);
    step();

    // Scoreboard path for x9.
    clear_in();
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    step();
    clear_in(); rs_addr[4:0] = 9;
    #1 chk("sb_stall", 64'(stall), 64'd1);
    step();
    lret_valid = 1; lret_rd = 9;         // same-cycle return still stalls
    #1 chk("sb_lret_same", 64'(stall), 64'd1);
    step();
    lret_valid = 0;
    #1 chk("sb_clear_stall", 64'(stall), 64'd0);
    chk("sb_clear_sel", 64'(fwd_sel[0]), 64'd0);
    step();

    // Simultaneous set and clear of x9: set wins.
    clear_in();
    issue_valid = 1; issue_long = 1; issue_rd = 9; lret_valid = 1; lret_rd = 9;
    step();
    clear_in(); rs_addr[4:0] = 9;
    #1 chk("simul_pend", 64'(stall), 64'd1);
    step();
    clear_in(); lret_valid = 1; lret_rd = 9;
    step();

    // x0 never matches.
    clear_in();
    stage_wr_en = '1; stage_dv = '1;
    for (int s = 0; s < NSTAGE; s++) stage_data[XLEN*s +: XLEN] = {$urandom, $urandom};
    #1 chk("x0_sel", 64'(fwd_sel), 64'd0);
    chk("x0_stall", 64'(stall), 64'd0);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREAD; i++) rs_addr[5*i +: 5] = 5'($urandom_range(0, 7));
      for (int s = 0; s < NSTAGE; s++) begin
        stage_rd[5*s +: 5] = 5'($urandom_range(0, 7));
        stage_data[XLEN*s +: XLEN] = {$urandom, $urandom};
      end
      stage_wr_en = NSTAGE'($urandom);
      stage_dv    = NSTAGE'($urandom) | NSTAGE'($urandom);
      issue_valid = 1'($urandom); issue_long = 1'($urandom); issue_rd = 5'($urandom_range(0, 7));
      lret_valid  = 1'($urandom); lret_rd = 5'($urandom_range(0, 7));
      step();
    end

    // Watchdog with a scoreboard hazard held on x9.
    clear_in();
    reset_pulse();
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    step();
    clear_in(); rs_addr[4:0] = 9;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) chk("wd_hang_pre", 64'(hang), 64'd0);
    end
    chk("wd_hang_set", 64'(hang), 64'd1);
    rs_addr = '0;
    step();
    chk("wd_hang_sticky", 64'(hang), 64'd1);
    rs_addr[4:0] = 9;
    reset_pulse();
    #1 chk("rst_pend_cleared", 64'(stall), 64'd0);
    step();

    // Statistics: ten stall cycles after reset.
    clear_in();
    stage_rd[0 +: 5] = 3; stage_wr_en = 5'b00001; rs_addr[4:0] = 3;
    repeat (10) step();
    #1 chk("stats_count", 64'(stall_cycles), STATS ? 64'd10 : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
